// File: rtl/bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
//
// Serial-to-parallel stage wrapped around a 2:1 bit multiplexer. The block
// selects one mux lane for a whole word (sel_o -> mux select), samples the
// mux output one bit per clock (din_i <- mux out), assembles WIDTH-bit words
// MSB-first and presents each completed word over a valid/ready handshake.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start_i  in   1      request to capture one word (IDLE, or HOLD with ready_i)
//   lane_i   in   1      lane for the word being started (0 = a, 1 = b)
//   sel_o    out  1      registered mux select
//   din_i    in   1      mux output bit
//   data_o   out  WIDTH  assembled word, held until the next word completes
//   valid_o  out  1      data_o holds a complete, unaccepted word
//   ready_i  in   1      downstream accepts data_o
//   busy_o   out  1      high while shifting or holding a word
// -----------------------------------------------------------------------------
module bit_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             lane_i,
    output logic             sel_o,
    input  logic             din_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   shifted;

    // The incoming bit enters at the LSB, so the first sampled bit has moved
    // up to the MSB by the time the last bit arrives.
    assign shifted = {shreg_q[WIDTH-2:0], din_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start_i) begin
                    sel_d   = lane_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // start_i/lane_i are ignored here: the lane is fixed per word.
                shreg_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    data_d  = shifted;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // A start coinciding with the accepting handshake launches the
                // next word directly, so no IDLE cycle is lost between words.
                if (ready_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        sel_d   = lane_i;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign sel_o   = sel_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    // Decoded straight from the state register so it tracks the FSM without lag.
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_bit_deserializer.sv
module tb_bit_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic         lane_i;
    logic         sel_o;
    logic         din_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         busy_o;

    logic         a_bit;
    logic         b_bit;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         lane;
        logic [W-1:0] a_word;
        logic [W-1:0] b_word;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    bit_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .lane_i  (lane_i),
        .sel_o   (sel_o),
        .din_i   (din_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    // 2:1 bit multiplexer surrounding the deserializer
    assign din_i = sel_o ? b_bit : a_bit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a word is accepted on the edge following a cycle where
    // valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(data_o), 32'hDEAD_BEEF);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_data", 32'(data_o), 32'(e));
            end
        end
    end

    // Issues start (from IDLE, or from HOLD with ready already high), then
    // feeds WIDTH bits MSB-first on both lanes. Optionally pulses start with
    // the opposite lane glitch_at bits into the word. Ends right after the
    // edge where valid must rise.
    task automatic run_word(input logic ln, input logic [W-1:0] aw,
                            input logic [W-1:0] bw, input int glitch_at);
        logic [W-1:0] e;
        e = ln ? bw : aw;
        start_i = 1'b1;
        lane_i  = ln;
        a_bit   = aw[W-1];
        b_bit   = bw[W-1];
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("e0_valid", 32'(valid_o), 0);
        check("e0_sel", 32'(sel_o), 32'(ln));
        check("e0_busy", 32'(busy_o), 1);
        for (int i = 0; i < W; i++) begin
            a_bit = aw[W-1-i];
            b_bit = bw[W-1-i];
            if (i == glitch_at) begin
                start_i = 1'b1;
                lane_i  = ~ln;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            check("valid_timing", 32'(valid_o), (i == W-1) ? 1 : 0);
            check("shift_sel", 32'(sel_o), 32'(ln));
            check("shift_busy", 32'(busy_o), 1);
        end
        check("word_data", 32'(data_o), 32'(e));
    endtask

    // Aborts a word with reset and verifies nothing leaks out afterwards.
    task automatic reset_and_idle(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_sel"}, 32'(sel_o), 0);
        check({tag, "_rst_data"}, 32'(data_o), 0);
        check({tag, "_rst_valid"}, 32'(valid_o), 0);
        check({tag, "_rst_busy"}, 32'(busy_o), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check({tag, "_post_valid"}, 32'(valid_o), 0);
            check({tag, "_post_busy"}, 32'(busy_o), 0);
        end
    endtask

    task automatic start_partial(input logic ln, input int nbits);
        start_i = 1'b1;
        lane_i  = ln;
        a_bit   = 1'b1;
        b_bit   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{lane: 1'b1, a_word: 8'h00, b_word: 8'hB2, exp_data: 8'hB2};
        vecs[1] = '{lane: 1'b0, a_word: 8'hFF, b_word: 8'h00, exp_data: 8'hFF};
        vecs[2] = '{lane: 1'b0, a_word: 8'h00, b_word: 8'hFF, exp_data: 8'h00};
        vecs[3] = '{lane: 1'b1, a_word: 8'h5A, b_word: 8'h3C, exp_data: 8'h3C};
        vecs[4] = '{lane: 1'b0, a_word: 8'h96, b_word: 8'h69, exp_data: 8'h96};

        rst_n   = 1'b0;
        start_i = 1'b0;
        lane_i  = 1'b0;
        ready_i = 1'b1;
        a_bit   = 1'b0;
        b_bit   = 1'b0;
        #3;
        check("init_sel", 32'(sel_o), 0);
        check("init_data", 32'(data_o), 0);
        check("init_valid", 32'(valid_o), 0);
        check("init_busy", 32'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset 3 bits into a word
        start_partial(1'b1, 3);
        reset_and_idle("mid_shift");

        // Table-driven words with ready held high
        for (int v = 0; v < 5; v++) begin
            run_word(vecs[v].lane, vecs[v].a_word, vecs[v].b_word, -1);
            @(posedge clk); #1;
            check("tbl_valid_drop", 32'(valid_o), 0);
            check("tbl_busy_drop", 32'(busy_o), 0);
            check("tbl_data_kept", 32'(data_o), 32'(vecs[v].exp_data));
        end

        // Backpressure: start pulses in HOLD are ignored
        ready_i = 1'b0;
        run_word(1'b1, 8'h00, 8'hB2, -1);
        for (int k = 0; k < 5; k++) begin
            start_i = (k % 2 == 0);
            lane_i  = 1'b0;
            @(posedge clk); #1;
            check("bp_valid", 32'(valid_o), 1);
            check("bp_data", 32'(data_o), 32'hB2);
            check("bp_sel", 32'(sel_o), 1);
            check("bp_busy", 32'(busy_o), 1);
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(valid_o), 0);
        check("bp_release_busy", 32'(busy_o), 0);

        // Back-to-back: accept in HOLD and start the next word on the same edge
        ready_i = 1'b0;
        run_word(1'b1, 8'h00, 8'hB2, -1);
        @(posedge clk); #1;
        check("b2b_hold", 32'(valid_o), 1);
        ready_i = 1'b1;
        run_word(1'b0, 8'hFF, 8'h00, -1);
        @(posedge clk); #1;
        check("b2b_end_valid", 32'(valid_o), 0);

        // start with a toggled lane mid-word is ignored
        run_word(1'b1, 8'h0F, 8'hC3, 4);
        @(posedge clk); #1;
        check("glitch_end_valid", 32'(valid_o), 0);

        // Reset mid-shift in the same run, then reset while holding a word
        start_partial(1'b0, 5);
        reset_and_idle("mid_shift2");
        ready_i = 1'b0;
        run_word(1'b0, 8'hA5, 8'h00, -1);
        reset_and_idle("in_hold");
        ready_i = 1'b1;

        // Recovery after reset
        run_word(1'b1, 8'h00, 8'h81, -1);
        @(posedge clk); #1;
        check("final_valid", 32'(valid_o), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
